// File: rtl/aes_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// aes_key_sched_ctrl
//
// Sequences an external AES-128 round-key engine through rounds 0..NR and
// stores every returned round key in a local (NR+1) x 128-bit register file.
// The stored keys can then be read back one per cycle.
//
// Handshake (engine side): in REQ the controller holds ke_en=1 and
// ke_round=r stable; the engine answers with a single-cycle ke_done pulse and
// ke_key valid in that same cycle. After each accepted ke_done, ke_en drops
// for exactly one GAP cycle before the next round is requested. If ke_done
// does not arrive within TMO REQ cycles, the run stops in ERR with sticky err.
//
// Read side: rd_en is a one-cycle request, and rd_valid answers it exactly one
// cycle later. rd_key is zero unless key_ready was high when the request was
// made and rd_round <= NR.
//
// Ports
//   clk        in   rising-edge clock
//   areset     in   asynchronous, active-low reset
//   start      in   one-cycle pulse that begins an expansion of key_in
//   key_in     in   128-bit cipher key (word1 = [127:96] ... word4 = [31:0])
//   busy       out  high in REQ and GAP
//   key_ready  out  high in DONE (all NR+1 round keys are stored)
//   err        out  sticky timeout flag
//   ke_en      out  engine enable
//   ke_round   out  round number to the engine (always equal to r)
//   ke_init    out  initial key words latched at start
//   ke_done    in   engine completion pulse
//   ke_key     in   engine round key, valid when ke_done=1
//   rd_en      in   read request
//   rd_round   in   round key index to read
//   rd_key     out  read data
//   rd_valid   out  read data valid (one cycle after rd_en)
//   dbg_state  out  current FSM state, for debug and checkers
// ---------------------------------------------------------------------------
module aes_key_sched_ctrl #(
  parameter int unsigned NR  = 10,
  parameter int unsigned TMO = 8
) (
  input  logic         clk,
  input  logic         areset,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         key_ready,
  output logic         err,
  output logic         ke_en,
  output logic [3:0]   ke_round,
  output logic [127:0] ke_init,
  input  logic         ke_done,
  input  logic [127:0] ke_key,
  input  logic         rd_en,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key,
  output logic         rd_valid,
  output logic [2:0]   dbg_state
);

  localparam logic [3:0] NR_L     = 4'(NR);
  // Last value of the wait counter before a REQ times out: the TMO-th REQ
  // cycle without ke_done moves to ERR.
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_GAP  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t         st_q;
  logic [3:0]     r_q;
  logic [7:0]     wait_q;
  logic           busy_q;
  logic           key_ready_q;
  logic           err_q;
  logic           ke_en_q;
  logic [127:0]   ke_init_q;

  logic [127:0]   store_q [0:NR];
  logic           st_wr;

  logic [127:0]   rd_key_d;
  logic [127:0]   rd_key_q;
  logic           rd_valid_q;

  // -------------------------------------------------------------------------
  // Control FSM. All outputs are registered and updated on the transition
  // into the state that owns them, so they are glitch-free and already valid
  // in the first cycle of each state.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      st_q        <= S_IDLE;
      r_q         <= '0;
      wait_q      <= '0;
      busy_q      <= 1'b0;
      key_ready_q <= 1'b0;
      err_q       <= 1'b0;
      ke_en_q     <= 1'b0;
      ke_init_q   <= '0;
    end else begin
      case (st_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            ke_init_q   <= key_in;
            r_q         <= '0;
            wait_q      <= '0;
            key_ready_q <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
            ke_en_q     <= 1'b1;
            st_q        <= S_REQ;
          end
        end

        S_REQ: begin
          if (ke_done) begin
            wait_q  <= '0;
            ke_en_q <= 1'b0;
            st_q    <= S_GAP;
          end else if (wait_q == TMO_LAST) begin
            wait_q      <= '0;
            ke_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            key_ready_q <= 1'b0;
            err_q       <= 1'b1;
            st_q        <= S_ERR;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end

        S_GAP: begin
          // r stops at NR; the last round goes straight to DONE.
          if (r_q == NR_L) begin
            busy_q      <= 1'b0;
            key_ready_q <= 1'b1;
            st_q        <= S_DONE;
          end else begin
            r_q     <= r_q + 4'd1;
            ke_en_q <= 1'b1;
            st_q    <= S_REQ;
          end
        end

        default: begin
          st_q    <= S_IDLE;
          busy_q  <= 1'b0;
          ke_en_q <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Key store. Only a ke_done seen in REQ writes; stray pulses elsewhere
  // (IDLE, GAP, DONE, ERR) leave the stored keys untouched.
  // -------------------------------------------------------------------------
  assign st_wr = (st_q == S_REQ) && ke_done;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      for (int i = 0; i <= int'(NR); i++) begin
        store_q[i] <= '0;
      end
    end else if (st_wr) begin
      store_q[r_q] <= ke_key;
    end
  end

  // -------------------------------------------------------------------------
  // Read port: one-cycle latency, one request per cycle. key_ready is low
  // for the whole expansion, so a read that coincides with a store write
  // returns zero rather than a partially updated store.
  // -------------------------------------------------------------------------
  always_comb begin
    rd_key_d = '0;
    if (rd_en && key_ready_q && (rd_round <= NR_L)) begin
      rd_key_d = store_q[rd_round];
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      rd_key_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_key_q   <= rd_key_d;
      rd_valid_q <= rd_en;
    end
  end

  assign busy      = busy_q;
  assign key_ready = key_ready_q;
  assign err       = err_q;
  assign ke_en     = ke_en_q;
  assign ke_round  = r_q;
  assign ke_init   = ke_init_q;
  assign rd_key    = rd_key_q;
  assign rd_valid  = rd_valid_q;
  assign dbg_state = st_q;

endmodule
